// File: rtl/sram_read_stream.sv
// Burst reader for an asynchronous SRAM. It issues sequential word reads and
// buffers the returned words in a small FIFO that feeds a valid/ready stream.
module sram_read_stream #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iBase_addr,
    input  logic [ADDR_W-1:0] iLength,
    input  logic [DATA_W-1:0] iMEM_DATA,
    input  logic              iREADY,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oMEM_OE_N,
    output logic              oMEM_WE_N,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oBusy,
    output logic              oDone
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                oe_n_q, oe_n_d;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d, count_after_pop;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dval_q, busy_q, done_q;
    logic                wr, pop, space;

    // The registered OE_N low marks the issue cycle; its word lands at the closing edge.
    assign wr              = ~oe_n_q;
    assign pop             = dval_q & iREADY;
    assign count_after_pop = count_q - CNT_W'(pop);
    assign count_d         = count_after_pop + CNT_W'(wr);
    assign rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
    assign space           = ({1'b0, count_q} + (CNT_W + 1)'(wr)) < (CNT_W + 1)'(FIFO_DEPTH);

    // Next-state and next-issue decision; the issue itself is registered onto the pins.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        oe_n_d      = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    if (iLength != '0) begin
                        state_d     = S_READ;
                        oe_n_d      = 1'b0;
                        addr_d      = iBase_addr;
                        remaining_d = iLength - ADDR_W'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end else if (space) begin
                    oe_n_d      = 1'b0;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (pop && (count_q == CNT_W'(1))) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next FIFO head: a stored word if one survives the pop, else the word arriving now.
    always_comb begin
        data_d = data_q;
        if (count_after_pop != '0) begin
            data_d = fifo_mem[rd_ptr_d];
        end else if (wr) begin
            data_d = iMEM_DATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            oe_n_q      <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            dval_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            oe_n_q      <= oe_n_d;
            wr_ptr_q    <= wr_ptr_q + PTR_W'(wr);
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            dval_q      <= (count_d != '0);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr) fifo_mem[wr_ptr_q] <= iMEM_DATA;
    end

    assign oMEM_ADDR = addr_q;
    assign oMEM_OE_N = oe_n_q;
    assign oMEM_WE_N = 1'b1;
    assign oDATA     = data_q;
    assign oDVAL     = dval_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
endmodule

// File: tb/tb_sram_read_stream.sv
// Bench for sram_read_stream: an SRAM model, a burst-level reference model checked
// every cycle, and directed plus randomized bursts with variable back-pressure.
module tb_sram_read_stream;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic              iStart;
    logic [ADDR_W-1:0] iBase_addr;
    logic [ADDR_W-1:0] iLength;
    logic [DATA_W-1:0] iMEM_DATA;
    logic              iREADY;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic              oMEM_OE_N;
    logic              oMEM_WE_N;
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic              oBusy;
    logic              oDone;

    sram_read_stream #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iBase_addr(iBase_addr),
        .iLength(iLength), .iMEM_DATA(iMEM_DATA), .iREADY(iREADY),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_OE_N(oMEM_OE_N), .oMEM_WE_N(oMEM_WE_N),
        .oDATA(oDATA), .oDVAL(oDVAL), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iCLK = ~iCLK;

    logic [DATA_W-1:0] salt;
    assign iMEM_DATA = oMEM_OE_N ? 16'hDEAD : (oMEM_ADDR[15:0] ^ salt);

    int checks;
    int errors;
    int cyc;
    int ready_mode;

    // Burst-level reference state
    logic              m_active;
    logic [ADDR_W-1:0] m_base;
    logic [ADDR_W-1:0] m_last;
    int                m_len;
    int                issued;
    int                popped;
    int                max_occ;
    int                m_start_cyc;
    int                done_cnt;
    int                done_cyc;
    logic [ADDR_W-1:0] issue_addr [$];
    int                issue_cyc [$];
    logic [DATA_W-1:0] got_data [$];
    int                xfer_cyc [$];

    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ salt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        int                occ;
        logic              pop;
        logic              exp_done;
        logic              was_active;
        logic [ADDR_W-1:0] exp_addr;
        forever begin
            @(negedge iCLK);
            cyc++;
            if (!iRST) begin
                m_active = 1'b0;
                issued   = 0;
                popped   = 0;
                m_last   = '0;
            end else begin
                occ        = issued - popped;
                was_active = m_active;
                exp_done   = m_active && (popped == m_len);
                chk("we_n", 32'(oMEM_WE_N), 32'd1);
                chk("busy", 32'(oBusy), 32'(m_active));
                chk("dval", 32'(oDVAL), 32'(occ > 0));
                if (oDVAL && occ > 0)
                    chk("data", 32'(oDATA), 32'(mem_f(m_base + ADDR_W'(popped))));
                chk("done", 32'(oDone), 32'(exp_done));
                if (!oMEM_OE_N) begin
                    exp_addr = m_base + ADDR_W'(issued);
                    chk("issue_allowed", 32'(m_active && issued < m_len), 32'd1);
                    chk("addr", 32'(oMEM_ADDR), 32'(exp_addr));
                    issue_addr.push_back(oMEM_ADDR);
                    issue_cyc.push_back(cyc);
                    m_last = exp_addr;
                    issued++;
                end else begin
                    chk("addr_hold", 32'(oMEM_ADDR), 32'(m_last));
                end
                pop = oDVAL && iREADY && (occ > 0);
                if (pop) begin
                    got_data.push_back(oDATA);
                    xfer_cyc.push_back(cyc);
                    popped++;
                end
                occ = issued - popped;
                chk("occupancy", 32'(occ <= DEPTH), 32'd1);
                if (occ > max_occ) max_occ = occ;
                if (oDone) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (exp_done) m_active = 1'b0;
                if (!was_active && iStart) begin
                    m_active    = 1'b1;
                    m_base      = iBase_addr;
                    m_len       = int'(iLength);
                    issued      = 0;
                    popped      = 0;
                    max_occ     = 0;
                    m_start_cyc = cyc + 1;
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge iCLK);
            #1;
            case (ready_mode)
                0:       iREADY = 1'b1;
                1:       iREADY = ($urandom_range(0, 3) != 0);
                default: iREADY = 1'b0;
            endcase
        end
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] base, input int len);
        @(posedge iCLK);
        #1;
        iStart     = 1'b1;
        iBase_addr = base;
        iLength    = ADDR_W'(len);
        @(posedge iCLK);
        #1;
        iStart     = 1'b0;
        iBase_addr = ADDR_W'($urandom);
        iLength    = ADDR_W'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_active) return;
            @(negedge iCLK);
            #1;
        end
        chk("burst_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_burst(input string name, input int bi, input int bd,
                               input logic [ADDR_W-1:0] base, input int len);
        logic [ADDR_W-1:0] a;
        chk({name, "_n_issue"}, 32'(issue_addr.size() - bi), 32'(len));
        chk({name, "_n_data"}, 32'(got_data.size() - bd), 32'(len));
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            if (bi + i < issue_addr.size()) chk({name, "_addr"}, 32'(issue_addr[bi + i]), 32'(a));
            if (bd + i < got_data.size()) chk({name, "_word"}, 32'(got_data[bd + i]), 32'(a[15:0] ^ salt));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_addr"}, 32'(oMEM_ADDR), 32'd0);
        chk({name, "_oe_n"}, 32'(oMEM_OE_N), 32'd1);
        chk({name, "_we_n"}, 32'(oMEM_WE_N), 32'd1);
        chk({name, "_data"}, 32'(oDATA), 32'd0);
        chk({name, "_dval"}, 32'(oDVAL), 32'd0);
        chk({name, "_busy"}, 32'(oBusy), 32'd0);
        chk({name, "_done"}, 32'(oDone), 32'd0);
    endtask

    initial begin
        int bi, bd, dc, len;
        logic [ADDR_W-1:0] base;
        checks = 0; errors = 0; cyc = 0; ready_mode = 0;
        m_active = 1'b0; m_base = '0; m_last = '0; m_len = 0;
        issued = 0; popped = 0; max_occ = 0; m_start_cyc = 0; done_cnt = 0; done_cyc = 0;
        salt = '0;
        iRST = 1'b0; iStart = 1'b0; iBase_addr = '0; iLength = '0; iREADY = 1'b1;
        fork
            monitor();
            ready_driver();
        join_none

        repeat (2) @(posedge iCLK);
        #1;
        check_reset_outputs("reset");
        @(negedge iCLK);
        #2;
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);

        // Straight 8-word burst, full throughput
        bi = issue_addr.size(); bd = got_data.size(); dc = done_cnt;
        start_burst(18'h00100, 8);
        wait_done(200);
        check_burst("b8", bi, bd, 18'h00100, 8);
        if (issue_cyc.size() >= bi + 8 && xfer_cyc.size() >= bd + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b8_issue_cycle", 32'(issue_cyc[bi + i] - m_start_cyc), 32'(i));
                chk("b8_xfer_cycle", 32'(xfer_cyc[bd + i] - m_start_cyc), 32'(i + 1));
            end
        end
        chk("b8_done_cycle", 32'(done_cyc - m_start_cyc), 32'd9);
        chk("b8_done_pulses", 32'(done_cnt - dc), 32'd1);
        @(negedge iCLK);
        #1;
        chk("b8_busy_after", 32'(oBusy), 32'd0);

        // Address wrap at the top of the space
        bi = issue_addr.size(); bd = got_data.size();
        start_burst(18'h3FFFE, 4);
        wait_done(200);
        check_burst("wrap", bi, bd, 18'h3FFFE, 4);
        if (issue_addr.size() >= bi + 4 && got_data.size() >= bd + 4) begin
            chk("wrap_a2", 32'(issue_addr[bi + 2]), 32'h00000);
            chk("wrap_a3", 32'(issue_addr[bi + 3]), 32'h00001);
            chk("wrap_d1", 32'(got_data[bd + 1]), 32'hFFFF);
            chk("wrap_d2", 32'(got_data[bd + 2]), 32'h0000);
        end

        // Back-pressure: 20 stalled cycles, buffer fills to depth
        bi = issue_addr.size(); bd = got_data.size(); dc = done_cnt;
        ready_mode = 2;
        start_burst(18'h00500, 16);
        repeat (19) @(posedge iCLK);
        #2;
        chk("stall_issues", 32'(issue_addr.size() - bi), 32'(DEPTH));
        chk("stall_max_occ", 32'(max_occ), 32'(DEPTH));
        ready_mode = 0;
        wait_done(400);
        check_burst("stall", bi, bd, 18'h00500, 16);
        chk("stall_done_pulses", 32'(done_cnt - dc), 32'd1);

        // Zero-length burst
        bi = issue_addr.size(); bd = got_data.size(); dc = done_cnt;
        start_burst(18'h00055, 0);
        wait_done(50);
        chk("len0_issues", 32'(issue_addr.size() - bi), 32'd0);
        chk("len0_words", 32'(got_data.size() - bd), 32'd0);
        chk("len0_done_cycle", 32'(done_cyc - m_start_cyc), 32'd0);
        chk("len0_done_pulses", 32'(done_cnt - dc), 32'd1);

        // Restart attempt mid-burst is ignored
        salt = 16'h5A3C;
        ready_mode = 1;
        bi = issue_addr.size(); bd = got_data.size(); dc = done_cnt;
        start_burst(18'h00800, 12);
        repeat (3) @(posedge iCLK);
        start_burst(18'h03000, 5);
        wait_done(800);
        check_burst("restart", bi, bd, 18'h00800, 12);
        chk("restart_done_pulses", 32'(done_cnt - dc), 32'd1);

        // Reset after three of ten words delivered
        bd = got_data.size();
        start_burst(18'h00200, 10);
        for (int i = 0; i < 500 && (got_data.size() - bd) < 3; i++) begin
            @(negedge iCLK);
            #1;
        end
        chk("rst_three_seen", 32'(got_data.size() - bd), 32'd3);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge iCLK);
        #2;
        iRST = 1'b1;
        ready_mode = 0;
        salt = '0;
        bi = issue_addr.size(); bd = got_data.size(); dc = done_cnt;
        start_burst(18'h00020, 2);
        wait_done(100);
        check_burst("after_rst", bi, bd, 18'h00020, 2);
        chk("after_rst_done", 32'(done_cnt - dc), 32'd1);

        // Randomized bursts with random back-pressure
        for (int k = 0; k < 12; k++) begin
            salt = DATA_W'($urandom);
            ready_mode = (k % 4 == 0) ? 0 : 1;
            base = ADDR_W'($urandom);
            len = $urandom_range(0, 40);
            bi = issue_addr.size(); bd = got_data.size(); dc = done_cnt;
            start_burst(base, len);
            if (k % 3 == 0 && len > 4) begin
                repeat (2) @(posedge iCLK);
                start_burst(ADDR_W'($urandom), $urandom_range(1, 40));
            end
            wait_done(3000);
            check_burst("rand", bi, bd, base, len);
            chk("rand_done", 32'(done_cnt - dc), 32'd1);
        end

        repeat (3) @(posedge iCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
